// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed 7-segment scan driver; optional SEG_LZB_EN leading-zero blanking
module seg_scan_mux #(
    parameter int DIGITS  = 4,
    parameter int BANKS   = 2,
    parameter int REFRESH = 12288,
    parameter int BLANK   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [BANKS*DIGITS*4-1:0]  d,
    input  logic [BANKS*DIGITS-1:0]    dp,
    input  logic [BANKS-1:0]           blank,
    output logic [DIGITS-1:0]          sel,
    output logic [BANKS*8-1:0]         q,
    output logic                       frame
);

    localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int DW = $clog2(DIGITS);
    localparam int NB = BANKS * DIGITS;

    localparam logic [CW-1:0] CNT_LAST     = CW'(REFRESH - 1);
    localparam logic [CW-1:0] CNT_SHOW_END = CW'(REFRESH - BLANK - 1);
    localparam logic [DW-1:0] DIG_LAST     = DW'(DIGITS - 1);

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DW-1:0]     digit, digit_nxt;
    logic              advance;

    logic [NB*4-1:0]   pend_d, act_d, act_d_nxt;
    logic [NB-1:0]     pend_dp, act_dp, act_dp_nxt;
    logic              pend_vld;

    logic [DIGITS-1:0] sel_nxt;
    logic [BANKS*8-1:0] q_nxt;

    int                dec_idx;
    logic [3:0]        dec_nib;
    logic              dec_dp;
    logic              dec_hide;

    // Hex to {a,b,c,d,e,f,g,dp} segment pattern, dp bit left clear
    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'hFC;
            4'h1: seg7 = 8'h60;
            4'h2: seg7 = 8'hDA;
            4'h3: seg7 = 8'hF2;
            4'h4: seg7 = 8'h66;
            4'h5: seg7 = 8'hB6;
            4'h6: seg7 = 8'hBE;
            4'h7: seg7 = 8'hE0;
            4'h8: seg7 = 8'hFE;
            4'h9: seg7 = 8'hF6;
            4'hA: seg7 = 8'hEE;
            4'hB: seg7 = 8'h3E;
            4'hC: seg7 = 8'h1A;
            4'hD: seg7 = 8'h7A;
            4'hE: seg7 = 8'h9E;
            default: seg7 = 8'h8E;
        endcase
    endfunction

    // Slot sequencing: SHOW for REFRESH-BLANK cycles, BLANK for the rest, then advance digit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        digit_nxt = digit;
        advance   = 1'b0;
        case (state)
            ST_SHOW: begin
                if (cnt == CNT_SHOW_END) begin
                    if (BLANK == 0) advance = 1'b1;
                    else            state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt == CNT_LAST) advance = 1'b1;
            end
            default: state_nxt = ST_SHOW;
        endcase
        if (advance) begin
            state_nxt = ST_SHOW;
            cnt_nxt   = '0;
            digit_nxt = (digit == DIG_LAST) ? '0 : digit + DW'(1);
        end
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SHOW;
            cnt   <= '0;
            digit <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            digit <= digit_nxt;
        end
    end

    // Active buffer only changes in the frame cycle; a load in that same cycle wins over pending
    always_comb begin
        act_d_nxt  = act_d;
        act_dp_nxt = act_dp;
        if (frame) begin
            if (load) begin
                act_d_nxt  = d;
                act_dp_nxt = dp;
            end else if (pend_vld) begin
                act_d_nxt  = pend_d;
                act_dp_nxt = pend_dp;
            end
        end
    end

    // Double buffer: pending collects loads, active is what the scan displays
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_d   <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
            act_d    <= '0;
            act_dp   <= '0;
        end else begin
            act_d  <= act_d_nxt;
            act_dp <= act_dp_nxt;
            if (frame) begin
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_d   <= d;
                pend_dp  <= dp;
                pend_vld <= 1'b1;
            end
        end
    end

    // Segment and select values for the slot position currently held in state/cnt/digit
    always_comb begin
        sel_nxt  = '1;
        q_nxt    = '0;
        dec_idx  = 0;
        dec_nib  = 4'h0;
        dec_dp   = 1'b0;
        dec_hide = 1'b0;
        if (state == ST_SHOW) sel_nxt[digit] = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            dec_idx  = b * DIGITS + DIGITS - 1 - int'(digit);
            dec_nib  = act_d_nxt[dec_idx*4 +: 4];
            dec_dp   = act_dp_nxt[dec_idx];
            dec_hide = 1'b0;
`ifdef SEG_LZB_EN
            // Hide a zero digit while everything to its left is zero; last digit always shows
            dec_hide = !dec_dp && (int'(digit) != DIGITS - 1);
            for (int k = 0; k < DIGITS; k++) begin
                if (k <= int'(digit) && act_d_nxt[(b*DIGITS + DIGITS - 1 - k)*4 +: 4] != 4'h0)
                    dec_hide = 1'b0;
            end
`endif
            if (state == ST_SHOW && !blank[b] && !dec_hide)
                q_nxt[b*8 +: 8] = seg7(dec_nib) | {7'b0, dec_dp};
        end
    end

    // Output registers: sel, q and frame all update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sel   <= '1;
            q     <= '0;
            frame <= 1'b0;
        end else begin
            sel   <= sel_nxt;
            q     <= q_nxt;
            frame <= advance && (digit == DIG_LAST);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [1:0]  blank;
    logic [3:0]  sel, sel_nb;
    logic [15:0] q, q_nb;
    logic        frame, frame_nb;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit track = 1'b0;

    // 10-unit clock
    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .BANKS(2), .REFRESH(8), .BLANK(2)) u_dut (
        .clk(clk), .rst(rst), .load(load), .d(d), .dp(dp), .blank(blank),
        .sel(sel), .q(q), .frame(frame)
    );

    seg_scan_mux #(.DIGITS(4), .BANKS(2), .REFRESH(8), .BLANK(0)) u_dut_nb (
        .clk(clk), .rst(rst), .load(load), .d(d), .dp(dp), .blank(blank),
        .sel(sel_nb), .q(q_nb), .frame(frame_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_sel(input int n, input bit gap);
        int pos;
        int slot;
        logic [3:0] s;
        pos  = (n - 1) % 8;
        slot = ((n - 1) / 8) % 4;
        s    = 4'hF;
        if (!gap || pos < 6) s[slot] = 1'b0;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (track) begin
            check("scan_sel", {28'b0, sel}, {28'b0, exp_sel(cyc, 1'b1)});
            check("scan_frame", {31'b0, frame}, {31'b0, (cyc % 32) == 0});
            check("nb_sel", {28'b0, sel_nb}, {28'b0, exp_sel(cyc, 1'b0)});
            check("nb_frame", {31'b0, frame_nb}, {31'b0, (cyc % 32) == 0});
        end
    endtask

    task automatic run_to(input int ph);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((cyc % 32) != ph && n < 64);
        if ((cyc % 32) != ph) check("run_to_bound", cyc % 32, ph);
    endtask

    task automatic pulse_load(input logic [31:0] dv);
        d    = dv;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        d     = '0;
        dp    = '0;
        blank = '0;

        // Reset state
        step();
        step();
        check("rst_sel", {28'b0, sel}, 32'hF);
        check("rst_q", {16'b0, q}, 32'h0);
        check("rst_frame", {31'b0, frame}, 32'h0);
        check("rst_nb_sel", {28'b0, sel_nb}, 32'hF);

        // Scan pattern over two frames; active buffer is zero so digits show "0"
        rst   = 1'b0;
        cyc   = 0;
        track = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            check("scan_q", {16'b0, q}, ((cyc - 1) % 8 < 6) ? 32'hFCFC : 32'h0);
            check("nb_q", {16'b0, q_nb}, 32'hFCFC);
        end

        // Decode after commit: bank0 digits 8,9,A,F and bank1 digits 0,1,2,3
        run_to(5);
        pulse_load(32'h0123_89AF);
        run_to(0);
        run_to(3);  check("dec_d0", {16'b0, q}, 32'hFCFE);
        run_to(11); check("dec_d1", {16'b0, q}, 32'h60F6);
        run_to(19); check("dec_d2", {16'b0, q}, 32'hDAEE);
        run_to(27); check("dec_d3", {16'b0, q}, 32'hF28E);

        // Load while digit 2 is lit: digits 2,3 keep old data until the frame
        run_to(18);
        pulse_load(32'h4567_CDE0);
        check("tear_d2", {16'b0, q}, 32'hDAEE);
        run_to(27); check("tear_d3", {16'b0, q}, 32'hF28E);
        run_to(3);  check("new_d0", {16'b0, q}, 32'h661A);

        // Load during the frame cycle commits directly
        run_to(0);
        pulse_load(32'hFEDC_7654);
        check("frm_load_d0", {16'b0, q}, 32'h8EE0);
        run_to(11); check("frm_load_d1", {16'b0, q}, 32'h9EBE);

        // Bank1 blanked, bank0 digit 3 decimal point
        blank = 2'b10;
        dp    = 8'h01;
        pulse_load(32'h0123_89AF);
        run_to(0);
        run_to(3);  check("blank_d0", {16'b0, q}, 32'h00FE);
        run_to(27); check("dp_d3", {16'b0, q}, 32'h008F);
        blank = 2'b00;
        step();     check("unblank_live", {16'b0, q}, 32'hF28F);
        dp    = 8'h00;

        // Reset during digit 2 blank gap discards pending data
        run_to(12);
        pulse_load(32'h1111_1111);
        run_to(23);
        rst   = 1'b1;
        track = 1'b0;
        step();
        check("mid_rst_sel", {28'b0, sel}, 32'hF);
        check("mid_rst_q", {16'b0, q}, 32'h0);
        check("mid_rst_frame", {31'b0, frame}, 32'h0);
        rst   = 1'b0;
        cyc   = 0;
        track = 1'b1;
        run_to(3);  check("post_rst_d0", {16'b0, q}, 32'hFCFC);
        run_to(0);
        run_to(3);  check("post_frm_d0", {16'b0, q}, 32'hFCFC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
